// File: rtl/aes_pkg.sv
// Shared types and constants for the AES inverse-cipher datapath blocks.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  localparam int NB_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } inv_sb_state_t;

endpackage

// File: rtl/aes_inv_subbytes_seq_if.sv
// Input/output valid-ready handshake bundle for aes_inv_subbytes_seq.
interface aes_inv_subbytes_seq_if
  import aes_pkg::*;
;
  logic   in_valid;
  logic   in_ready;
  state_t in_state;
  logic   out_valid;
  logic   out_ready;
  state_t out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_inv_subbytes_seq_inv_sbox.sv
// Combinational AES inverse S-box, plus the forward S-box used only when
// AES_INV_SBOX_CHECK_EN is defined. Tables are stored entry 0 at the MSB.
module inv_sbox
  import aes_pkg::*;
(
  input  byte_t din,
  output byte_t dout
);
  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign dout = INV_TBL[{~din, 3'b000} +: 8];
endmodule

`ifdef AES_INV_SBOX_CHECK_EN
module sbox
  import aes_pkg::*;
(
  input  byte_t din,
  output byte_t dout
);
  localparam logic [2047:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = FWD_TBL[{~din, 3'b000} +: 8];
endmodule
`endif

// File: rtl/aes_inv_subbytes_seq.sv
// Iterative InvSubBytes: LANES bytes per cycle, lowest byte first.
// Define AES_INV_SBOX_CHECK_EN to add a forward-S-box round-trip check on err.
//
// state | meaning
// IDLE  | waiting for a state on the input handshake
// RUN   | substituting LANES bytes of the work register per edge
// DONE  | result presented, waiting for out_ready
module aes_inv_subbytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  aes_inv_subbytes_seq_if.slave  bus,
  output logic                   busy,
  output logic                   err
);
  localparam int NCYC = NB_BYTES / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  inv_sb_state_t st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  state_t        work, work_nx;
  byte_t         lane_in  [LANES];
  byte_t         lane_out [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++)
      lane_in[l] = work[(int'(cnt) * LANES + l) * 8 +: 8];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_inv (.din(lane_in[l]), .dout(lane_out[l]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st   <= IDLE;
      cnt  <= '0;
      work <= '0;
    end else begin
      st   <= st_nx;
      cnt  <= cnt_nx;
      work <= work_nx;
    end
  end

  always_comb begin
    st_nx         = st;
    cnt_nx        = cnt;
    work_nx       = work;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    case (st)
      IDLE: begin
        busy         = 1'b0;
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          work_nx = bus.in_state;
          cnt_nx  = '0;
          st_nx   = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++)
          work_nx[(int'(cnt) * LANES + l) * 8 +: 8] = lane_out[l];
        if (cnt == LAST) begin
          cnt_nx = '0;
          st_nx  = DONE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  assign bus.out_state = work;

`ifdef AES_INV_SBOX_CHECK_EN
  byte_t            fwd_out [LANES];
  logic [LANES-1:0] miss;
  logic             err_q;

  for (genvar l = 0; l < LANES; l++) begin : g_chk
    sbox u_fwd (.din(lane_out[l]), .dout(fwd_out[l]));
    assign miss[l] = (fwd_out[l] != lane_in[l]);
  end

  // Sticky until reset or the next accepted state.
  always_ff @(posedge clk) begin
    if (!rst_n)                          err_q <= 1'b0;
    else if (st == IDLE && bus.in_valid) err_q <= 1'b0;
    else if (st == RUN && |miss)         err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_aes_inv_subbytes_seq.sv
// Directed bench for aes_inv_subbytes_seq: LANES=4 control tests plus a
// 256-value sweep on LANES=1/4/16 instances checked through a forward S-box.
module tb_aes_inv_subbytes_seq;
  import aes_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   in_valid;
  state_t in_state;
  logic   out_ready;
  int     n_cmp = 0;
  int     n_bad = 0;

  always #5 clk = ~clk;

  aes_inv_subbytes_seq_if b1 ();
  aes_inv_subbytes_seq_if b4 ();
  aes_inv_subbytes_seq_if b16 ();

  assign b1.in_valid   = in_valid;
  assign b1.in_state   = in_state;
  assign b1.out_ready  = out_ready;
  assign b4.in_valid   = in_valid;
  assign b4.in_state   = in_state;
  assign b4.out_ready  = out_ready;
  assign b16.in_valid  = in_valid;
  assign b16.in_state  = in_state;
  assign b16.out_ready = out_ready;

  logic bsy [3];
  logic er  [3];
  logic ov  [3];
  state_t os [3];

  aes_inv_subbytes_seq #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .busy(bsy[0]), .err(er[0]));
  aes_inv_subbytes_seq #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave), .busy(bsy[1]), .err(er[1]));
  aes_inv_subbytes_seq #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .bus(b16.slave), .busy(bsy[2]), .err(er[2]));

  assign ov[0] = b1.out_valid;
  assign ov[1] = b4.out_valid;
  assign ov[2] = b16.out_valid;
  assign os[0] = b1.out_state;
  assign os[1] = b4.out_state;
  assign os[2] = b16.out_state;

  localparam logic [2047:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic state_t fwd_state(input state_t s);
    logic [2047:0] t;
    state_t r;
    t = FWD;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = t[{~s[i*8 +: 8], 3'b000} +: 8];
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Accept one state on the LANES=4 instance, then measure latency and result.
  task automatic run_l4(input string tag, input state_t din, input state_t exp);
    int n;
    in_state = din;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_state = ~din;
    n = 0;
    while (!b4.out_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_lat"}, 128'(n), 128'd4);
    check_eq({tag, "_busy"}, 128'(bsy[1]), 128'd1);
    check_eq({tag, "_data"}, b4.out_state, exp);
    tick();
    check_eq({tag, "_ready"}, 128'(b4.in_ready), 128'd1);
  endtask

  initial begin
    int lat [3];
    state_t val [3];

    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    tick();
    do_reset();

    check_eq("rst_in_ready",  128'(b4.in_ready), 128'd1);
    check_eq("rst_out_valid", 128'(b4.out_valid), 128'd0);
    check_eq("rst_out_state", b4.out_state, 128'd0);
    check_eq("rst_busy",      128'(bsy[1]), 128'd0);
    check_eq("rst_err",       128'(er[1]), 128'd0);

    // all 0x63 -> all 0x00, with busy visible right after the accept edge
    in_state = {16{8'h63}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("run_busy", 128'(bsy[1]), 128'd1);
    check_eq("run_in_ready", 128'(b4.in_ready), 128'd0);
    tick(); tick(); tick();
    check_eq("run_no_valid_yet", 128'(b4.out_valid), 128'd0);
    tick();
    check_eq("v63_valid", 128'(b4.out_valid), 128'd1);
    check_eq("v63_data", b4.out_state, 128'd0);
    check_eq("done_busy", 128'(bsy[1]), 128'd1);
    tick();

    run_l4("zero", '0, {16{8'h52}});
    run_l4("ramp", 128'h76abd7fe2b670130c56f6bf27b777c63,
                   128'h0f0e0d0c0b0a09080706050403020100);

    // Backpressure in DONE
    out_ready = 1'b0;
    in_state  = {16{8'h16}};
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_valid", 128'(b4.out_valid), 128'd1);
      check_eq("bp_data",  b4.out_state, {16{8'hff}});
      check_eq("bp_in_ready", 128'(b4.in_ready), 128'd0);
      in_valid = c[0];
      in_state = {16{8'h00}};
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("bp_hold_end", b4.out_state, {16{8'hff}});
    tick();
    check_eq("bp_release_ready", 128'(b4.in_ready), 128'd1);
    check_eq("bp_release_valid", 128'(b4.out_valid), 128'd0);

    // Reset during RUN, then immediate new state
    in_state = {16{8'hed}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    do_reset();
    check_eq("mr_valid", 128'(b4.out_valid), 128'd0);
    check_eq("mr_ready", 128'(b4.in_ready), 128'd1);
    check_eq("mr_busy",  128'(bsy[1]), 128'd0);
    run_l4("mr_next", {16{8'hed}}, {16{8'h53}});

    // Sweep all byte values on the three lane widths in lockstep
    do_reset();
    for (int x = 0; x < 256; x++) begin
      for (int k = 0; k < 3; k++) begin
        lat[k] = 0;
        val[k] = '0;
      end
      in_state = {16{8'(x)}};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_state = '1;
      for (int c = 1; c <= 20; c++) begin
        for (int k = 0; k < 3; k++) begin
          if (er[k] !== 1'b0) check_eq("sweep_err", 128'(er[k]), 128'd0);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
          if (lat[k] == 0 && ov[k]) begin
            lat[k] = c;
            val[k] = os[k];
          end
        end
      end
      check_eq("sweep_lat_l1",  128'(lat[0]), 128'd16);
      check_eq("sweep_lat_l4",  128'(lat[1]), 128'd4);
      check_eq("sweep_lat_l16", 128'(lat[2]), 128'd1);
      check_eq("sweep_data_l1",  fwd_state(val[0]), {16{8'(x)}});
      check_eq("sweep_data_l4",  fwd_state(val[1]), {16{8'(x)}});
      check_eq("sweep_data_l16", fwd_state(val[2]), {16{8'(x)}});
      check_eq("sweep_err_end", 128'({er[0], er[1], er[2]}), 128'd0);
      if (x == 8'h16) check_eq("sweep_16", val[2], {16{8'hff}});
      if (x == 8'hed) check_eq("sweep_ed", val[0], {16{8'h53}});
      if (x == 8'h00) check_eq("sweep_00", val[1], {16{8'h52}});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
